// File: rtl/pc_pkg.sv
// Shared constants and state type for the program-counter stage.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
    localparam int          PC_INC         = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_src_mux.sv
// WIDTH x NSRC next-PC selector; source 0 is PC+4, unused select codes fall back to source 0.
module pc_src_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4
) (
    input  logic [WIDTH-1:0]            i_pc_plus4,
    input  logic [(NSRC-1)*WIDTH-1:0]   i_targets,
    input  logic [$clog2(NSRC)-1:0]     i_sel,
    output logic [WIDTH-1:0]            o_target,
    output logic                        o_redirect
);

    localparam int SELW = $clog2(NSRC);

    always_comb begin
        o_target   = i_pc_plus4;
        o_redirect = 1'b0;
        for (int k = 1; k < NSRC; k++) begin
            if (i_sel == SELW'(k)) begin
                o_target   = i_targets[(k-1)*WIDTH +: WIDTH];
                o_redirect = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: next-PC select, stall hold, one-entry redirect buffer.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               NSRC       = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [(NSRC-1)*WIDTH-1:0]   targets,
    input  logic [$clog2(NSRC)-1:0]     pc_source,
    input  logic                        stall,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_plus4,
    output logic                        redirect_pending,
    output logic                        exc_misalign,
    output logic [WIDTH-1:0]            bad_addr
);

    pc_state_e        r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_cand;
    logic             w_redirect;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_load_pc;
    logic             w_misalign;

    assign w_pc_plus4 = r_pc + WIDTH'(PC_INC);

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_src_mux (
        .i_pc_plus4 (w_pc_plus4),
        .i_targets  (targets),
        .i_sel      (pc_source),
        .o_target   (w_cand),
        .o_redirect (w_redirect)
    );

    // A buffered redirect takes priority over whatever is selected this cycle.
    assign w_load    = (r_state == HELD) ? r_pend : w_cand;
    assign w_load_pc = w_misalign ? EXC_VECTOR : w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
        end else if (stall) begin
            if (r_state == RUN && w_redirect) begin
                r_pend  <= w_cand;
                r_state <= HELD;
            end
        end else begin
            r_pc    <= w_load_pc;
            r_state <= RUN;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic             r_exc;
    logic [WIDTH-1:0] r_bad;

    // Checked when the value is applied, so a buffered target is judged on release.
    assign w_misalign = |w_load[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc <= 1'b0;
            r_bad <= '0;
        end else begin
            r_exc <= !stall && w_misalign;
            if (!stall && w_misalign)
                r_bad <= w_load;
        end
    end

    assign exc_misalign = r_exc;
    assign bad_addr     = r_bad;
`else
    assign w_misalign   = 1'b0;
    assign exc_misalign = 1'b0;
    assign bad_addr     = '0;
`endif

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = (r_state == HELD);

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit (NSRC=3): reference model pushes expectations, monitor checks each cycle.
module tb_pc_next_unit;

    localparam int          W    = 32;
    localparam int          NS   = 3;
    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam logic [31:0] EXCV = 32'h8000_0180;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [(NS-1)*W-1:0]  targets;
    logic [1:0]           pc_source;
    logic                 stall;
    logic [W-1:0]         pc, pc_plus4, bad_addr;
    logic                 redirect_pending, exc_misalign;

    pc_next_unit #(.WIDTH(W), .NSRC(NS)) dut (
        .clk(clk), .rst_n(rst_n), .targets(targets), .pc_source(pc_source),
        .stall(stall), .pc(pc), .pc_plus4(pc_plus4),
        .redirect_pending(redirect_pending), .exc_misalign(exc_misalign),
        .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic        pend;
        logic        exc;
        logic [31:0] bad;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: architectural PC, a one-slot redirect buffer, trap outputs.
    logic [31:0] m_pc;
    bit          m_has_pend;
    logic [31:0] m_pend;
    logic        m_exc;
    logic [31:0] m_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_has_pend = 0; m_pend = 0; m_exc = 0; m_bad = 0;
    endtask

    task automatic model_apply(input logic [31:0] v);
        bit trap;
        trap = 0;
`ifdef PC_ALIGN_CHECK_EN
        trap = (v % 4) != 0;
`endif
        if (trap) begin
            m_pc = EXCV; m_bad = v; m_exc = 1;
        end else begin
            m_pc = v; m_exc = 0;
        end
    endtask

    task automatic model_step(input int src, input logic st, input logic [31:0] t1, input logic [31:0] t2);
        logic [31:0] cand;
        int eff;
        eff  = (src >= NS) ? 0 : src;
        cand = (eff == 0) ? m_pc + 32'd4 : (eff == 1 ? t1 : t2);
        if (st) begin
            m_exc = 0;
            if (!m_has_pend && eff != 0) begin
                m_has_pend = 1; m_pend = cand;
            end
        end else if (m_has_pend) begin
            m_has_pend = 0;
            model_apply(m_pend);
        end else begin
            model_apply(cand);
        end
    endtask

    // One clock of stimulus; the expectation is queued after the edge it describes.
    task automatic step(input int src, input logic st, input logic [31:0] t1, input logic [31:0] t2);
        exp_t e;
        pc_source = 2'(src);
        stall     = st;
        targets   = {t2, t1};
        model_step(src, st, t1, t2);
        @(posedge clk);
        e.pc = m_pc; e.p4 = m_pc + 32'd4; e.pend = m_has_pend; e.exc = m_exc; e.bad = m_bad;
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("mon_pc", pc, e.pc);
            chk("mon_pc_plus4", pc_plus4, e.p4);
            chk("mon_pending", 32'(redirect_pending), 32'(e.pend));
            chk("mon_exc", 32'(exc_misalign), 32'(e.exc));
            chk("mon_bad_addr", bad_addr, e.bad);
        end
    end

    initial begin
        logic [31:0] r1, r2;
        rst_n = 1'b0; stall = 0; pc_source = 0; targets = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            pc_source = 2'($urandom_range(0, 3));
            stall     = 1'($urandom);
            targets   = {$urandom, $urandom};
            @(negedge clk);
            chk("reset_pc", pc, RPC);
        end
        chk("reset_pc_plus4", pc_plus4, 32'h0040_0004);
        chk("reset_pending", 32'(redirect_pending), 0);
        chk("reset_exc", 32'(exc_misalign), 0);
        chk("reset_bad", bad_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(0, 0, $urandom, $urandom);
            chk("seq_pc", pc, RPC + 32'(4 * (i + 1)));
        end

        step(2, 1, 32'h0, 32'h0040_0100);
        chk("stall_pending", 32'(redirect_pending), 1);
        chk("stall_pc_hold", pc, 32'h0040_0010);
        step(1, 1, 32'h0040_0200, 32'h0);
        chk("stall_second_pending", 32'(redirect_pending), 1);
        step(1, 0, 32'h0040_0300, 32'h0);
        chk("release_pc", pc, 32'h0040_0100);
        chk("release_pending", 32'(redirect_pending), 0);

        step(3, 0, 32'h1234_5678, 32'h9abc_def0);
        chk("oor_select", pc, 32'h0040_0104);

        step(2, 0, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step(0, 0, 32'h0, 32'h0);
        chk("wrap_next", pc, 32'h0);

        step(1, 0, 32'h0040_0102, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_pc", pc, EXCV);
        chk("align_exc", 32'(exc_misalign), 1);
        chk("align_bad", bad_addr, 32'h0040_0102);
        step(0, 0, 32'h0, 32'h0);
        chk("align_exc_pulse", 32'(exc_misalign), 0);
        chk("align_bad_hold", bad_addr, 32'h0040_0102);
`else
        chk("noalign_pc", pc, 32'h0040_0102);
        chk("noalign_exc", 32'(exc_misalign), 0);
        step(0, 0, 32'h0, 32'h0);
        chk("noalign_next", pc, 32'h0040_0106);
`endif

        step(2, 1, 32'h0, 32'h0050_0000);
        chk("held_before_reset", 32'(redirect_pending), 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midheld_reset_pending", 32'(redirect_pending), 0);
        chk("midheld_reset_pc", pc, RPC);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 32'h0, 32'h0);
        chk("after_reset_seq", pc, 32'h0040_0004);

        for (int i = 0; i < 400; i++) begin
            r1 = $urandom; r2 = $urandom;
            if ($urandom_range(0, 7) != 0) r1[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) r2[1:0] = 2'b00;
            step($urandom_range(0, 3), 1'($urandom_range(0, 2) == 0), r1, r2);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter stage for the MIPS datapath: selects the next PC from N sources (internal PC+4 plus NSRC-1 external targets), registers it, and holds it under stall. A one-entry redirect buffer keeps branch/jump targets that arrive during a stall. An optional alignment checker traps misaligned targets to the exception vector. It drives the instruction-memory address and feeds PC+4 back to the branch/jump adders.

## Interface
- WIDTH, 32, PC and target width in bits (≥ 8)
- NSRC, 4, number of next-PC sources including internal PC+4 (2..8)
- RESET_PC, 32'h0040_0000, PC value while and after reset
- EXC_VECTOR, 32'h8000_0180, PC loaded on misalignment trap
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- targets  in  (NSRC-1)*WIDTH  external targets; slice k-1 is source k (branch, jump, jr, …)
- pc_source  in  $clog2(NSRC)  source select; 0 = PC+4
- stall  in  1  hold PC this cycle
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc + 4, combinational, modulo 2^WIDTH
- redirect_pending  out  1  buffered redirect is waiting
- exc_misalign  out  1  one-cycle trap pulse (registered)
- bad_addr  out  WIDTH  last misaligned target (registered)

## Operation
- Reset (rst_n=0, asynchronous): pc=RESET_PC, redirect_pending=0, pending target=0, exc_misalign=0, bad_addr=0.
- pc_source ≥ NSRC is treated as 0.
- "Redirect" = pc_source ≠ 0 in a given cycle; candidate = selected source.
- States: RUN (pending empty), HELD (pending valid). redirect_pending = (state==HELD).
- RUN, stall=0: pc ← candidate. No state change.
- RUN, stall=1, redirect: capture candidate into pending, go HELD; pc holds.
- RUN, stall=1, no redirect: pc holds.
- HELD, stall=1: pc holds; any new redirect is dropped (older redirect wins).
- HELD, stall=0: pc ← pending target, go RUN; concurrent pc_source ignored this cycle.
- Arithmetic: pc_plus4 wraps; 32'hFFFF_FFFC → 0.

## Timing
- Select-to-pc latency: 1 cycle (value visible after next rising edge).
- Redirect latency under stall: pc takes pending target on the first edge with stall=0.
- exc_misalign is high for exactly the cycle after the trapping edge; bad_addr updates on the same edge and holds until the next trap.
- pc_plus4 has zero latency from pc; no combinational path from any input to pc, redirect_pending, exc_misalign.
- rst_n asserted mid-stall or mid-HELD discards the pending target.

## Configuration
- PC_ALIGN_CHECK_EN defined: any value about to load into pc (candidate or pending) with bits [1:0]≠0 instead loads EXC_VECTOR, sets bad_addr to that value, pulses exc_misalign. Candidate captured into pending is checked when it is applied, not at capture.
- Undefined: no check; pc loads the value unmodified (bits [1:0] kept); exc_misalign tied 0, bad_addr tied 0.

## Structure
- Package pc_pkg: default RESET_PC, EXC_VECTOR, PC_INC=4, state enum {RUN, HELD}.
- One sub-module: pc_src_mux — parametrised WIDTH × NSRC combinational selector with out-of-range-to-0 rule. It generalises the existing 4:1 PC mux.
- Top holds the pc register, pending register, FSM and alignment check.

## Test plan
- Reset: rst_n low for 3 cycles with random inputs → pc=32'h0040_0000, pc_plus4=32'h0040_0004, all flags 0.
- Sequential: pc_source=0, 4 cycles from reset → pc = 0x00400004, …08, …0C, …10.
- Stalled redirect: stall=1, pc_source=2, target=0x00400100 for 1 cycle, then pc_source=1, target=0x00400200 while stall still 1; release stall → redirect_pending=1 during stall, pc=0x00400100 on first unstalled edge, 0x00400200 dropped.
- Out-of-range select: NSRC=3, pc_source=3 → pc advances by 4.
- Wrap: force pc to 0xFFFFFFFC via jump target → pc_plus4=0, next sequential pc=0.
- PC_ALIGN_CHECK_EN: jump target 0x00400102 → pc=0x80000180, exc_misalign high one cycle, bad_addr=0x00400102; without macro → pc=0x00400102, exc_misalign stays 0.
